byte_serializer: RTL
====================

# byte_serializer

Parallel-to-serial transmit stage that accepts a byte through a valid/ready handshake and emits it LSB-first as a serial bit (`ser_data`) plus a one-cycle bit strobe (`ser_en`). It sits directly upstream of the team's 8-bit serial-in shift register, which shifts each new bit in at the MSB end. With its data input on `ser_data` and its enable on `ser_en`, that register holds the original byte in `y[7:0]` in the cycle `done` is high. A programmable clocks-per-bit divider sets the serial rate.

## Interface
- `WIDTH`, default 8: bits per frame; legal range ≥ 2.
- `DIV`, default 1: clock cycles per serial bit; legal range ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_data`  in  WIDTH  parallel word to transmit.
- `in_ready`  out  1  block can accept a word; equals `!busy && !rst`.
- `ser_data`  out  1  current serial bit, LSB first.
- `ser_en`  out  1  one-cycle strobe marking the sample cycle of `ser_data`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the last bit strobe.

## Operation
- The state machine has two states, IDLE and SHIFT. Internal state:
  - WIDTH-bit data latch;
  - bit index, clog2(WIDTH) bits;
  - divider count, clog2(DIV) bits, at least 1 bit.
- Reset, asynchronous: state returns to IDLE and index and count clear. Outputs on reset:
  - `ser_data` = 0, `ser_en` = 0, `busy` = 0, `done` = 0;
  - `in_ready` = 0 while `rst` is high, 1 after release.
- IDLE: `in_ready` = 1. Acceptance means `in_valid && in_ready` sampled at a rising edge. On acceptance:
  - latch `in_data`, clear index and count, go to SHIFT;
  - `ser_data` takes `in_data[0]`.
- SHIFT: `busy` = 1 and `in_ready` = 0. `in_valid`/`in_data` are ignored, and changes to `in_data` have no effect on the frame.
- Bit i is held on `ser_data` for exactly DIV cycles. `ser_en` is high only in the last cycle of each bit window.
- After the strobe for bit WIDTH-1:
  - state returns to IDLE;
  - `done` = 1 for one cycle;
  - `ser_data` returns to 0.
- Back-to-back: acceptance is legal in the `done` cycle. The next frame's bit 0 window then starts in the following cycle, so the minimum gap between frames is one idle cycle.
- All outputs except `in_ready` are registered. `in_ready` is combinational from state and `rst` only, with no path from `in_valid`.
- Reset mid-frame aborts the frame immediately:
  - no further strobes;
  - no `done`;
  - latched data discarded.

## Timing
- Let E0 be the acceptance edge, and number the cycles after it 1, 2, ….
- Bit i window: cycles i·DIV+1 … (i+1)·DIV. `ser_en` is high in cycle (i+1)·DIV.
- `busy` is high in cycles 1 … WIDTH·DIV.
- `done` is high in cycle WIDTH·DIV+1, with `in_ready` = 1 in the same cycle.
- Latency from acceptance to first strobe: DIV cycles. Frame length: WIDTH·DIV cycles.
- DIV = 1: `ser_en` is high continuously for WIDTH cycles. The downstream register samples at edges E1…E_WIDTH and holds the full word during the `done` cycle.
- Divider count wraps DIV-1 → 0 at each strobe. Bit index saturates at WIDTH-1, and the terminal strobe is detected at index WIDTH-1 with count DIV-1.

## Test plan
- Basic frame (WIDTH=8, DIV=1): send 0xA5. Required response:
  - `ser_data` in cycles 1…8 = 1,0,1,0,0,1,0,1;
  - `ser_en` high in cycles 1…8 and `done` high in cycle 9;
  - downstream shift register `y` = 0xA5 in cycle 9.
- Back-to-back (DIV=1): hold `in_valid` high with 0x3C, then 0xC3 presented in the `done` cycle. Required response:
  - second acceptance at the `done` cycle;
  - `y` = 0x3C, then `y` = 0xC3 nine cycles later;
  - exactly 16 strobes.
- Divider (DIV=4): send 0x81. Required response:
  - `ser_en` high in cycles 4, 8, …, 32, each one cycle wide;
  - `ser_data` = 1 in cycles 1–4 and 29–32, 0 in between;
  - `busy` high in cycles 1–32 and `done` high in cycle 33.
- Input stability: during a 0x5A frame, toggle `in_data` every cycle with `in_valid` = 1. Required response:
  - `in_ready` = 0 throughout the frame;
  - serialized word remains 0x5A;
  - no extra acceptance occurs.
- Reset mid-frame (DIV=1): send 0xFF and assert `rst` in cycle 4 for 2 cycles. Required response:
  - all outputs 0 immediately;
  - no `done`;
  - after release, `in_ready` = 1, and a new 0x0F frame serializes correctly.
- Idle behaviour: with `in_valid` = 0 for 20 cycles after reset, require `ser_en` = `busy` = `done` = 0, `ser_data` = 0 and `in_ready` = 1.

Source files
------------

// File: rtl/byte_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serializer_if
//  Description : Handshake and serial-output bundle of the byte serializer.
//                The master side offers words and observes the serial stream;
//                the slave side is the serializer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface byte_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_data;
    logic             ser_en;
    logic             busy;
    logic             done;

    // Producer of words / consumer of the serial stream
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ser_data,
        input  ser_en,
        input  busy,
        input  done
    );

    // The serializer
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ser_data,
        output ser_en,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serializer
//  Description : Parallel-to-serial transmit stage. Accepts a WIDTH-bit word
//                on a valid/ready handshake and emits it LSB first on
//                ser_data, holding each bit for DIV clocks and strobing
//                ser_en in the last clock of every bit window. done pulses
//                for one clock after the final strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input wire             clk,
    input wire             rst,
    byte_serializer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    // With one clock per bit every bit window is also its own strobe cycle.
    localparam logic c_DIV_ONE = (DIV == 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [WIDTH-1:0]   r_data;      // remaining bits, current bit in [0]
    logic [c_IDX_W-1:0] r_idx;       // index of the bit now on ser_data
    logic [c_CNT_W-1:0] r_cnt;       // clock position inside the bit window
    logic               r_ser_data;
    logic               r_ser_en;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_ser_data_nxt;
    logic               w_ser_en_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_ready;
    logic               w_accept;
    logic               w_bit_last;
    logic               w_frame_last;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_IDX_W-1:0] w_idx_inc;

    // in_ready depends only on state and reset so that upstream may derive
    // in_valid from it without creating a combinational loop.
    assign w_ready      = (r_state == IDLE) && !rst;
    assign w_accept     = bus.in_valid && w_ready;

    assign w_bit_last   = (r_cnt == c_CNT_LAST);
    assign w_frame_last = w_bit_last && (r_idx == c_IDX_LAST);
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_idx_inc    = (r_idx == c_IDX_LAST) ? r_idx : (r_idx + 1'b1);

    // Next-state and next-output decode; all outputs default to idle values.
    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_ser_data_nxt = 1'b0;
        w_ser_en_nxt   = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = SHIFT;
                    w_data_nxt     = bus.in_data;
                    w_idx_nxt      = c_IDX_ZERO;
                    w_cnt_nxt      = c_CNT_ZERO;
                    w_ser_data_nxt = bus.in_data[0];
                    w_ser_en_nxt   = c_DIV_ONE;
                    w_busy_nxt     = 1'b1;
                end
            end

            SHIFT: begin
                if (w_frame_last) begin
                    // Terminal strobe just happened: close the frame.
                    w_state_nxt = IDLE;
                    w_idx_nxt   = c_IDX_ZERO;
                    w_cnt_nxt   = c_CNT_ZERO;
                    w_done_nxt  = 1'b1;
                end else if (w_bit_last) begin
                    // Bit window ended: move to the next bit.
                    w_data_nxt     = r_data >> 1;
                    w_idx_nxt      = w_idx_inc;
                    w_cnt_nxt      = c_CNT_ZERO;
                    w_ser_data_nxt = r_data[1];
                    w_ser_en_nxt   = c_DIV_ONE;
                    w_busy_nxt     = 1'b1;
                end else begin
                    // Still inside the window; strobe on its last clock.
                    w_cnt_nxt      = w_cnt_inc;
                    w_ser_data_nxt = r_data[0];
                    w_ser_en_nxt   = (w_cnt_inc == c_CNT_LAST);
                    w_busy_nxt     = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame and discards the latched word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ser_data <= 1'b0;
            r_ser_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ser_data <= w_ser_data_nxt;
            r_ser_en   <= w_ser_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.ser_data = r_ser_data;
    assign bus.ser_en   = r_ser_en;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
